if_fetch_unit: RTL

//  Instruction fetch unit: front end of the pipeline feeding the IF/ID register.

---
 rtl/if_fetch_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC and drives a single-outstanding req/gnt/rvalid bus.
// It presents registered pc_o/inst_o to IF/ID and inserts NOP bubbles when nothing valid is available.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        BUF
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] target_pc;
    logic [31:0] buf_pc;
    logic [31:0] buf_inst;
    logic        discard;
    logic [31:0] branch_target;
    logic        data_arrives;
    logic        data_usable;

    assign branch_target = branch_addr_i & 32'hFFFF_FFFC;
    assign data_arrives  = (state == WAIT) && ibus_rvalid_i;
    assign data_usable   = data_arrives && !discard;

    // The bus address is the fetch PC; it only moves while no request is pending on the bus.
    assign ibus_addr_o = fetch_pc;
    assign ibus_req_o  = (state == REQ);

    // IF/ID output register: branch bubbles win, hold freezes, otherwise fresh data,
    // the buffered word, or a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_o   <= 32'h0;
            inst_o <= NOP_INST;
        end else if (branch_flag_i) begin
            pc_o   <= 32'h0;
            inst_o <= NOP_INST;
        end else if (!hold_i) begin
            if (data_usable) begin
                pc_o   <= fetch_pc;
                inst_o <= ibus_rdata_i;
            end else if (state == BUF) begin
                pc_o   <= buf_pc;
                inst_o <= buf_inst;
            end else begin
                pc_o   <= 32'h0;
                inst_o <= NOP_INST;
            end
        end
    end

    // Fetch sequencing. A branch that lands while a transaction is in flight cannot
    // cancel it, so the target is parked and the returning word is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            target_pc <= RESET_PC;
            buf_pc    <= 32'h0;
            buf_inst  <= NOP_INST;
            discard   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (branch_flag_i) begin
                        fetch_pc <= branch_target;
                    end
                    state <= REQ;
                end
                REQ: begin
                    if (branch_flag_i) begin
                        target_pc <= branch_target;
                        discard   <= 1'b1;
                    end
                    if (ibus_gnt_i) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (data_arrives) begin
                        if (branch_flag_i) begin
                            fetch_pc <= branch_target;
                            discard  <= 1'b0;
                            state    <= REQ;
                        end else if (discard) begin
                            fetch_pc <= target_pc;
                            discard  <= 1'b0;
                            state    <= REQ;
                        end else if (hold_i) begin
                            buf_pc   <= fetch_pc;
                            buf_inst <= ibus_rdata_i;
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= BUF;
                        end else begin
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= REQ;
                        end
                    end else if (branch_flag_i) begin
                        target_pc <= branch_target;
                        discard   <= 1'b1;
                    end
                end
                BUF: begin
                    if (branch_flag_i) begin
                        fetch_pc <= branch_target;
                        state    <= REQ;
                    end else if (!hold_i) begin
                        state <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
